// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a BOOT/RUN/HALT controller and an FD
//   (fetch->decode) pipeline register.
//   - imem_addr is driven combinationally from the PC register; the
//     instruction memory answers combinationally on imem_rdata.
//   - BOOT lasts one cycle after reset and loads a bubble.
//   - RUN fetches one word per cycle unless decode stalls.
//   - A word whose opcode equals HALT_OPCODE is passed on as valid, and
//     fetching then stops in HALT until execute redirects with a branch.
//   - A branch from execute wins over a stall and squashes the FD register.
//   - A bubble always carries instruction_decode == 16'h0000. Opcode 0000
//     is a legal instruction, so decode must qualify with valid_decode.
//
//   Optional feature (macro FETCH_PERF_CNT_EN):
//     defined   -> fetch_count counts every valid load into the FD register
//                  (wraps at 16 bits).
//     undefined -> fetch_count is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction_decode,
  output logic [15:0] pc_decode,
  output logic        valid_decode,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;

  // Redirect applies in RUN and HALT only; during BOOT it is ignored.
  logic redirect;
  // This cycle loads a real instruction into the FD register.
  logic load_valid;
  // The word being fetched carries the halt opcode.
  logic is_halt_word;

  assign imem_addr    = pc;
  assign redirect     = branch_taken && (state != BOOT);
  assign load_valid   = (state == RUN) && !branch_taken && !stall;
  assign is_halt_word = (imem_rdata[15:12] == HALT_OPCODE);
  assign halted       = (state == HALT);

  // Fetch controller: next state, PC and FD register in one sequential block.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= BOOT;
      pc                 <= RESET_PC;
      instruction_decode <= 16'h0000;
      pc_decode          <= 16'h0000;
      valid_decode       <= 1'b0;
    end else if (redirect) begin
      // Squash the FD register and restart fetching at the target.
      state              <= RUN;
      pc                 <= branch_target;
      instruction_decode <= 16'h0000;
      valid_decode       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          // One bubble cycle with the PC held, then start fetching.
          instruction_decode <= 16'h0000;
          valid_decode       <= 1'b0;
          state              <= RUN;
        end
        RUN: begin
          if (load_valid) begin
            instruction_decode <= imem_rdata;
            pc_decode          <= pc;
            valid_decode       <= 1'b1;
            if (is_halt_word) begin
              state <= HALT;
            end else begin
              pc <= pc + 16'd1;  // wraps FFFF -> 0000
            end
          end
          // stall: PC and FD register hold their values
        end
        HALT: begin
          // Keep feeding bubbles until execute redirects, stall or not.
          instruction_decode <= 16'h0000;
          valid_decode       <= 1'b0;
        end
        default: begin
          state              <= BOOT;
          instruction_decode <= 16'h0000;
          valid_decode       <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;

  // Performance counter: one per valid instruction handed to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 16'h0000;
    end else if (load_valid) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage: reset, straight-line fetch, stall,
//   branch over stall, halt and restart, PC wrap, asynchronous reset during
//   stall. Instruction memory is a combinational array in the bench.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instruction_decode;
  logic [15:0] pc_decode;
  logic        valid_decode;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:65535];

  int checks;
  int failures;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_stage #(
    .RESET_PC   (16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .instruction_decode(instruction_decode),
    .pc_decode         (pc_decode),
    .valid_decode      (valid_decode),
    .halted            (halted),
    .fetch_count       (fetch_count)
  );

  assign imem_rdata = mem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected counter value: the hand count with the feature, zero without.
  function automatic logic [15:0] exp_fc(input int n);
    return PERF ? 16'(n) : 16'h0000;
  endfunction

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the FD register and PC in one go.
  task automatic check_fd(input string tag, input logic [15:0] instr, input logic [15:0] pcd,
                          input logic vld, input logic [15:0] addr);
    check({tag, ".instr"}, instruction_decode, instr);
    check({tag, ".pc_dec"}, pc_decode, pcd);
    check({tag, ".valid"}, {15'd0, valid_decode}, {15'd0, vld});
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h8807;
    mem[16'h0001] = 16'h8102;
    mem[16'h0002] = 16'h0281;
    mem[16'h0003] = 16'hF000;
    mem[16'h0040] = 16'h1234;
    mem[16'hFFFF] = 16'h5555;

    // Reset state
    step();
    step();
    check_fd("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    check("reset.halted", {15'd0, halted}, 16'h0000);
    check("reset.fc", fetch_count, 16'h0000);
    rst = 1'b0;

    // Edge 1: BOOT bubble, PC held
    step();
    check_fd("boot", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    // Edges 2..4: straight-line stream
    step();
    check_fd("e2", 16'h8807, 16'h0000, 1'b1, 16'h0001);
    step();
    check_fd("e3", 16'h8102, 16'h0001, 1'b1, 16'h0002);
    step();
    check_fd("e4", 16'h0281, 16'h0002, 1'b1, 16'h0003);

    // Halt word at address 3: captured valid, PC holds
    step();
    check_fd("halt_cap", 16'hF000, 16'h0003, 1'b1, 16'h0003);
    check("halt_cap.halted", {15'd0, halted}, 16'h0001);
    check("halt_cap.fc", fetch_count, exp_fc(4));
    step();
    check_fd("halt_b1", 16'h0000, 16'h0003, 1'b0, 16'h0003);
    check("halt_b1.halted", {15'd0, halted}, 16'h0001);
    stall = 1'b1;
    step();
    check_fd("halt_b2", 16'h0000, 16'h0003, 1'b0, 16'h0003);
    check("halt_b2.fc", fetch_count, exp_fc(4));

    // Branch out of HALT to 0 (with stall still high)
    branch_taken  = 1'b1;
    branch_target = 16'h0000;
    step();
    check_fd("hbr", 16'h0000, 16'h0003, 1'b0, 16'h0000);
    check("hbr.halted", {15'd0, halted}, 16'h0000);
    branch_taken = 1'b0;
    stall        = 1'b0;
    step();
    check_fd("resume0", 16'h8807, 16'h0000, 1'b1, 16'h0001);
    step();
    check_fd("resume1", 16'h8102, 16'h0001, 1'b1, 16'h0002);

    // Stall for two cycles while pc_decode = 1
    stall = 1'b1;
    step();
    check_fd("stall1", 16'h8102, 16'h0001, 1'b1, 16'h0002);
    step();
    check_fd("stall2", 16'h8102, 16'h0001, 1'b1, 16'h0002);
    check("stall2.fc", fetch_count, exp_fc(6));
    stall = 1'b0;
    step();
    check_fd("unstall", 16'h0281, 16'h0002, 1'b1, 16'h0003);

    // Branch together with stall: branch wins (and beats the halt word at 3)
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    stall         = 1'b1;
    step();
    check_fd("brst", 16'h0000, 16'h0002, 1'b0, 16'h0040);
    check("brst.halted", {15'd0, halted}, 16'h0000);
    branch_taken = 1'b0;
    stall        = 1'b0;
    step();
    check_fd("brtgt", 16'h1234, 16'h0040, 1'b1, 16'h0041);
    check("brtgt.fc", fetch_count, exp_fc(8));

    // PC wrap at FFFF
    branch_taken  = 1'b1;
    branch_target = 16'hFFFF;
    step();
    check_fd("wrap_br", 16'h0000, 16'h0040, 1'b0, 16'hFFFF);
    branch_taken = 1'b0;
    step();
    check_fd("wrap_ff", 16'h5555, 16'hFFFF, 1'b1, 16'h0000);
    step();
    check_fd("wrap_00", 16'h8807, 16'h0000, 1'b1, 16'h0001);
    check("wrap.fc", fetch_count, exp_fc(10));

    // Asynchronous reset between edges during a stall
    stall = 1'b1;
    step();
    check_fd("pre_rst", 16'h8807, 16'h0000, 1'b1, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check_fd("arst", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    check("arst.halted", {15'd0, halted}, 16'h0000);
    check("arst.fc", fetch_count, 16'h0000);
    #1;
    rst   = 1'b0;
    stall = 1'b0;

    // Restart: bubble, then three valid fetches
    step();
    check_fd("r_boot", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    step();
    check_fd("r_e2", 16'h8807, 16'h0000, 1'b1, 16'h0001);
    step();
    check_fd("r_e3", 16'h8102, 16'h0001, 1'b1, 16'h0002);
    step();
    check_fd("r_e4", 16'h0281, 16'h0002, 1'b1, 16'h0003);
    check("r.fc", fetch_count, exp_fc(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
